msh_in_buf: RTL
===============

// Module: msh_in_buf
// PURPOSE
//  Per-plane, per-direction credit-managed input buffer at each msh_node ingress port (NB/SB/EB/WB; wr_req, rd_req, rd_rsp).
//  Captures messages arriving from the neighbouring node, holds them in a flop FIFO and presents them to the node arbiter.
//  Returns one credit upstream for every entry the arbiter pops.
//  Flags protocol violations (push into a full buffer, pop from an empty one).
// PARAMETERS
//  W      72  message width in bits (req/rsp struct packed with its dbus)
//  DEPTH  4   entries; must be >=2, need not be a power of 2; equals the upstream initial credit count
//  AW     $clog2(DEPTH+1)  occupancy width (derived, not overridable)
// PORTS
//  mclk        in   1      mesh clock
//  i_reset     in   1      synchronous reset, active high
//  i_vld       in   1      incoming message valid (upstream spent one credit)
//  i_msg       in   W      incoming message
//  i_pop       in   1      arbiter consumes the head entry this cycle
//  o_vld       out  1      head entry valid
//  o_msg       out  W      head entry; undefined (held) when o_vld=0
//  o_crdt_rtn  out  1      one-cycle credit-return pulse to upstream
//  o_occ       out  AW     entries currently held
//  o_ovfl_err  out  1      sticky: push attempted while full with no pop
//  o_udfl_err  out  1      sticky: pop attempted while empty
// BEHAVIOUR
//  Reset: all outputs are 0 on the cycle after i_reset is sampled high, and wr_ptr=rd_ptr=0.
//    Storage contents are not reset.
//  Reset mid-operation: all entries are discarded and no credits are returned for them; the upstream resets in the same cycle.
//  Push: i_vld=1 writes i_msg at wr_ptr on the mclk edge.
//    The entry is visible on o_vld/o_msg the next cycle, so input-to-output latency is 1 cycle. There is no bypass.
//  Pop: i_pop=1 with o_vld=1 advances rd_ptr. o_msg then shows the next entry the following cycle.
//  Pointers: each pointer increments modulo DEPTH; value DEPTH-1 wraps to 0. o_occ is a separate counter, never derived from pointers.
//  Credit: o_crdt_rtn=1 exactly one cycle after each accepted pop, registered. Total credits returned equal total pops.
//  Simultaneous push and pop:
//    - Non-full, non-empty: both take effect and o_occ is unchanged.
//    - Empty: the pop is ignored and treated as an underflow; the push is taken.
//    - Full (o_occ=DEPTH): the push is accepted because the pop frees the head slot in the same edge. o_occ stays DEPTH.
//  Full with push and no pop: the message is dropped, state is unchanged, no credit is returned, and o_ovfl_err is set.
//  Empty with pop: ignored, and o_udfl_err is set.
//  Error flags stay set until reset.
//  o_vld = (o_occ != 0). o_msg = mem[rd_ptr], registered read path, with no combinational path from i_vld to o_vld.
// STRUCTURE
//  Shared msh_pkg gets:
//    - MSH_IN_BUF_DEPTH (default 4)
//    - msh_in_buf_err_t (packed struct {ovfl, udfl}) for later CSR aggregation in msh_ctrl
//  Inside msh_node: one instance per plane x direction x message class, in a generate loop.
//  Single flat module with no sub-module. Storage is a flop array, not a RAM macro, because DEPTH is small.
// TESTING
//  1. Reset, then 4 pushes of msgs 0x1..0x4 with no pop -> o_occ=4, o_vld=1, o_msg=0x1, no o_crdt_rtn, errors 0.
//  2. From that full state, 4 consecutive pops -> o_msg goes 0x2,0x3,0x4; o_crdt_rtn pulses on 4 cycles, each 1 cycle after its pop; o_occ reaches 0.
//  3. Ten back-to-back cycles of push and pop together starting from occ=1 (DEPTH=4, pointers wrap twice) -> output order matches input order; o_occ stays 1.
//  4. Full, then push 0xAA with no pop -> 0xAA is dropped, o_ovfl_err=1, o_occ=4.
//     Full, then push 0xBB with pop -> 0xBB is accepted, o_occ=4, no error.
//  5. Empty with i_pop=1 -> o_udfl_err=1, no credit, o_occ=0.
//     Empty with push and pop together -> occ=1, udfl set.
//  6. occ=3, assert i_reset for 1 cycle -> next cycle all outputs 0, the following push appears 1 cycle later, and no stale credit pulse is emitted.
//  Also: DEPTH=3 regression, plus a scoreboard assertion that the o_crdt_rtn count equals the accepted-pop count.

Source files
------------

// File: rtl/msh_pkg.sv
// rtl/msh_pkg.sv - shared mesh package: input-buffer depth and error record
//
// Purpose:
//   Constants and types shared by the msh_* blocks.
//   MSH_IN_BUF_DEPTH  entries per ingress buffer. It also sets the upstream
//                     initial credit count.
//   msh_in_buf_err_t  sticky error pair reported by each msh_in_buf. msh_ctrl
//                     aggregates these into its CSRs.

package msh_pkg;

    localparam int MSH_IN_BUF_DEPTH = 4;

    typedef struct packed {
        logic ovfl;
        logic udfl;
    } msh_in_buf_err_t;

    // Returns 1 when either sticky flag of a buffer is set, for CSR summary bits.
    function automatic logic msh_in_buf_err_any(input msh_in_buf_err_t e);
        return e.ovfl | e.udfl;
    endfunction

endpackage

// File: rtl/msh_in_buf.sv
// rtl/msh_in_buf.sv - credit-managed flop FIFO at one msh_node ingress port
//
// Purpose:
//   Captures messages from the neighbouring node and holds them in a small
//   flop FIFO. The FIFO is presented to the node arbiter. The block returns
//   one credit upstream for each popped entry and flags protocol violations.
//
// Ports:
//   mclk        in   1   mesh clock
//   i_reset     in   1   synchronous reset, active high
//   i_vld       in   1   incoming message valid (upstream spent a credit)
//   i_msg       in   W   incoming message
//   i_pop       in   1   arbiter consumes the head entry this cycle
//   o_vld       out  1   head entry valid
//   o_msg       out  W   head entry; held when o_vld=0
//   o_crdt_rtn  out  1   one-cycle credit-return pulse, one per accepted pop
//   o_occ       out  AW  entries currently held
//   o_ovfl_err  out  1   sticky: push while full with no pop
//   o_udfl_err  out  1   sticky: pop while empty

module msh_in_buf
    import msh_pkg::*;
#(
    parameter int W     = 72,
    parameter int DEPTH = MSH_IN_BUF_DEPTH,
    localparam int AW   = $clog2(DEPTH + 1)
) (
    input  logic          mclk,
    input  logic          i_reset,
    input  logic          i_vld,
    input  logic [W-1:0]  i_msg,
    input  logic          i_pop,
    output logic          o_vld,
    output logic [W-1:0]  o_msg,
    output logic          o_crdt_rtn,
    output logic [AW-1:0] o_occ,
    output logic          o_ovfl_err,
    output logic          o_udfl_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [AW-1:0]   occ_nxt;
    logic [W-1:0]    head_nxt;
    logic            full;
    logic            empty;
    logic            pop_ok;
    logic            push_ok;
    msh_in_buf_err_t err_q;

    // Pointers wrap at DEPTH, so DEPTH does not have to be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (o_occ == AW'(DEPTH));
    assign empty = (o_occ == '0);

    // A pop is only honoured when there is something to pop. When the buffer
    // is full, a simultaneous pop frees the head slot on the same edge, so the
    // push is still taken. When full, wr_ptr == rd_ptr, so the write lands in
    // the slot being vacated.
    assign pop_ok  = i_pop & ~empty;
    assign push_ok = i_vld & (~full | pop_ok);

    always_comb begin
        occ_nxt = o_occ;
        if (push_ok && !pop_ok) begin
            occ_nxt = o_occ + AW'(1);
        end else if (pop_ok && !push_ok) begin
            occ_nxt = o_occ - AW'(1);
        end
    end

    // o_msg is registered, so the next head is chosen here from the state
    // the edge will produce:
    //  - When the last entry is popped together with a push, the new head is
    //    the incoming message. mem[] does not hold it yet.
    //  - When the buffer is empty, a push becomes the head directly.
    //  - Otherwise a pop exposes the next stored slot.
    always_comb begin
        head_nxt = o_msg;
        if (pop_ok) begin
            if (o_occ == AW'(1)) begin
                if (push_ok) begin
                    head_nxt = i_msg;
                end
            end else begin
                head_nxt = mem[ptr_inc(rd_ptr)];
            end
        end else if (empty && push_ok) begin
            head_nxt = i_msg;
        end
    end

    // Storage is deliberately not reset; the pointers and occupancy define
    // which slots are live.
    always_ff @(posedge mclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_msg;
        end
    end

    always_ff @(posedge mclk) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_occ      <= '0;
            o_vld      <= 1'b0;
            o_msg      <= '0;
            o_crdt_rtn <= 1'b0;
            err_q      <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            o_occ      <= occ_nxt;
            o_vld      <= (occ_nxt != '0);
            o_msg      <= head_nxt;
            o_crdt_rtn <= pop_ok;
            if (i_vld && !push_ok) begin
                err_q.ovfl <= 1'b1;
            end
            if (i_pop && empty) begin
                err_q.udfl <= 1'b1;
            end
        end
    end

    assign o_ovfl_err = err_q.ovfl;
    assign o_udfl_err = err_q.udfl;

endmodule
